// File: rtl/multicycle_main_controller.sv
// Main control FSM for a multicycle datapath: fetch/decode, then per-class
// execute/memory/writeback sequences, with MemReady stretching memory cycles.
module multicycle_main_controller (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] InstrClass,
  input  logic       InstrSub,
  input  logic       Zero,
  input  logic       RTypeWritePermit,
  input  logic       MemReady,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IorD,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       RegWrite,
  output logic       MemToReg,
  output logic       ALUSrcA,
  output logic       ALUOp,
  output logic       InstrDone,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource
);

  typedef enum logic [3:0] {
    FETCH, DECODE, R_EXEC, R_WB, MEM_ADDR,
    MEM_READ, MEM_WB, MEM_WRITE, BRANCH, JUMP
  } state_e;

  state_e state_q, state_d;

  // Zero gates PCWriteCond outside this block; it never steers the FSM.
  logic zero_unused;
  assign zero_unused = Zero;

  always_ff @(posedge clk) begin
    if (rst) state_q <= FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FETCH:     if (MemReady) state_d = DECODE;
      DECODE: begin
        unique case (InstrClass)
          2'b00:        state_d = R_EXEC;
          2'b01, 2'b10: state_d = MEM_ADDR;
          default:      state_d = InstrSub ? JUMP : BRANCH;
        endcase
      end
      R_EXEC:    state_d = R_WB;
      R_WB:      state_d = FETCH;
      MEM_ADDR: begin
        unique case (InstrClass)
          2'b01:   state_d = MEM_READ;
          2'b10:   state_d = MEM_WRITE;
          default: state_d = FETCH;
        endcase
      end
      MEM_READ:  if (MemReady) state_d = MEM_WB;
      MEM_WB:    state_d = FETCH;
      MEM_WRITE: if (MemReady) state_d = FETCH;
      BRANCH:    state_d = FETCH;
      JUMP:      state_d = FETCH;
      default:   state_d = FETCH;
    endcase
  end

  // rst forces every output low so nothing is written while reset is held.
  always_comb begin
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IorD        = 1'b0;
    IRWrite     = 1'b0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    RegWrite    = 1'b0;
    MemToReg    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUOp       = 1'b0;
    InstrDone   = 1'b0;
    ALUSrcB     = 2'b00;
    PCSource    = 2'b00;
    if (!rst) begin
      unique case (state_q)
        FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = 2'b01;
          ALUOp   = 1'b1;
          IRWrite = MemReady;
          PCWrite = MemReady;
        end
        DECODE: begin
          ALUSrcB = 2'b11;
          ALUOp   = 1'b1;
        end
        R_EXEC: ALUSrcA = 1'b1;
        R_WB: begin
          RegWrite  = RTypeWritePermit;
          InstrDone = 1'b1;
        end
        MEM_ADDR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
          ALUOp   = 1'b1;
        end
        MEM_READ: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
        end
        MEM_WB: begin
          RegWrite  = 1'b1;
          MemToReg  = 1'b1;
          InstrDone = 1'b1;
        end
        MEM_WRITE: begin
          MemWrite  = 1'b1;
          IorD      = 1'b1;
          InstrDone = MemReady;
        end
        BRANCH: begin
          ALUSrcA     = 1'b1;
          PCSource    = 2'b01;
          PCWriteCond = 1'b1;
          InstrDone   = 1'b1;
        end
        JUMP: begin
          PCSource  = 2'b10;
          PCWrite   = 1'b1;
          InstrDone = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
